datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
- Hardwired control unit that drives the bus-based datapath.
- Generates every register in/out strobe, the ALU operation code, IncPc and the memory read/write requests.
- Steps the datapath through fetch, decode and execute T-states for a fixed 32-bit instruction set.
- Waits on a memory-ready handshake, with a timeout counter that traps to a FAULT state.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for mem_ready per access before FAULT (1..255).
- NUM_GPR, 16: number of general registers addressed by 4-bit fields; width of reg_in and reg_out.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  leave IDLE and begin fetching; level-sampled.
- ir  input  32  current IR contents from the datapath.
- mem_ready  input  1  memory access complete; valid while read or mem_write is high.
- pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out  output  1 each  bus drivers.
- reg_out  output  NUM_GPR  one-hot GPR bus driver.
- mar_in, mdr_in, ir_in, y_in, z_in, pc_in, hi_in, lo_in  output  1 each  register load enables.
- reg_in  output  NUM_GPR  one-hot GPR load enable.
- inc_pc  output  1  ALU computes bus+1 this cycle.
- alu_ctrl  output  4  ALU operation code.
- read  output  1  MDR mux selects memory data; memory read request.
- mem_write  output  1  memory write request (data from MDR, address from MAR).
- busy  output  1  high in any state except IDLE, HALT, FAULT.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.

Behaviour:
- Instruction fields: opcode = ir[31:27]; Ra = ir[26:23]; Rb = ir[22:19]; Rc = ir[18:15].
- Opcodes: LD 00000, ST 00010, ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ADDI 01100, MUL 01111, DIV 10000, MFHI 10111, MFLO 11000, NOP 11001, HALT 11010. Any other opcode -> FAULT.
- Outputs: Moore-decoded from registered state; all zero in IDLE/HALT/FAULT and during reset.
- Invariant: at most one bus driver (pc/zlow/zhigh/mdr/hi/lo/c_out or one reg_out bit) is asserted per cycle.
- IDLE: wait for start=1, then go to T0 on the next edge.
- T0: pc_out, mar_in, inc_pc, z_in.
- T1: zlow_out, pc_in, read, mdr_in.
  - Stay in T1 until mem_ready=1.
  - PC loads only in the first T1 cycle; pc_in is low while waiting.
- T2: mdr_out, ir_in. Then go to T3, or decode directly for HALT/NOP/illegal.
- R-type (ADD..SHL):
  - T3: reg_out[Rb], y_in.
  - T4: reg_out[Rc], alu_ctrl=op, z_in.
  - T5: zlow_out, reg_in[Ra].
  - Then T0.
- ADDI:
  - T3: reg_out[Rb], y_in.
  - T4: c_out, ADD, z_in.
  - T5: zlow_out, reg_in[Ra].
- MUL/DIV:
  - T3: reg_out[Ra], y_in.
  - T4: reg_out[Rb], op, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
- LD:
  - T3: reg_out[Rb], y_in.
  - T4: c_out, ADD, z_in.
  - T5: zlow_out, mar_in.
  - T6: read, mdr_in; wait on mem_ready.
  - T7: mdr_out, reg_in[Ra].
- ST:
  - T3–T5 as LD.
  - T6: reg_out[Ra], mdr_in (read=0).
  - T7: mem_write; wait on mem_ready.
- MFHI / MFLO: T3: hi_out or lo_out, reg_in[Ra].
- HALT: enter HALT; only reset exits. NOP: T2 -> T0.
- Memory timeout:
  - Wait counter clears on entering a memory state and increments each cycle mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - mem_ready=1 in the same cycle the limit is reached counts as success.
- Reset mid-instruction: state -> IDLE and counter -> 0 immediately (asynchronous); all strobes drop without waiting for a clock edge.
- start while busy: ignored.

Optional Feature:
- Macro: DATAPATH_SEQUENCER_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - Before each T0, the FSM waits in state PAUSE until a rising edge of step, detected with an internal registered copy of step.
  - busy stays high in PAUSE.
- When undefined: no step port; T0 follows the end of an instruction directly.

Decomposition:
- Package datapath_pkg: opcode constants, ALU code constants (ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHL 0101, MUL 0110, DIV 0111), state enum, field bit positions.
- One sub-module, gpr_select_decoder: 4-bit field + enable -> NUM_GPR one-hot; instantiated once for reg_in and once for reg_out.

Test Plan:
- Reset low then high, start=1, ir=ADD R1,R2,R3 (0x18918000), mem_ready=1 -> cycles T0–T5 = 6 clocks; T3 reg_out=0x0004, T4 reg_out=0x0008 with alu_ctrl=0000, T5 reg_in=0x0002; back to T0.
- LD R4 with mem_ready delayed 3 cycles in T1 and T6 -> read held 4 cycles each time; pc_in high exactly 1 cycle; T7 reg_in=0x0010.
- ST with mem_ready never asserted, MEM_TIMEOUT=15 -> fault=1 after 15 wait cycles in T7; all strobes 0.
- MUL R5,R6 -> T5 lo_in=1 with zlow_out=1; T6 hi_in=1 with zhigh_out=1; alu_ctrl=0110 in T4.
- Opcode 11111 -> FAULT one cycle after T2. HALT -> halted=1, held until reset; reset asserted in T4 of ADD -> all outputs 0 asynchronously.
- With DATAPATH_SEQUENCER_STEP_EN: step held low -> remains in PAUSE with no strobes; one step pulse -> exactly one instruction executes.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, ALU codes, IR field positions and FSM states
// shared by the hardwired datapath sequencer.
package datapath_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_PAUSE,
    S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7,
    S_HALT, S_FAULT
  } state_e;

  function automatic logic [3:0] alu_code(
    input logic [4:0] op
  );
    logic [3:0] c;
    c = ALU_ADD;
    case (op)
      OP_SUB:  c = ALU_SUB;
      OP_AND:  c = ALU_AND;
      OP_OR:   c = ALU_OR;
      OP_SHR:  c = ALU_SHR;
      OP_SHL:  c = ALU_SHL;
      OP_MUL:  c = ALU_MUL;
      OP_DIV:  c = ALU_DIV;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gpr_select_decoder.sv
// gpr_select_decoder: 4-bit register field plus enable to a
// one-hot GPR strobe vector.
module gpr_select_decoder #(
  parameter int NUM_GPR = 16
) (
  input  logic [3:0]         sel_i,
  input  logic               en_i,
  output logic [NUM_GPR-1:0] onehot_o
);

  // one strobe per register, only when enabled
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_bit
    assign onehot_o[g] = en_i && ({28'd0, sel_i} == 32'(g));
  end

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: hardwired T-state control unit for the bus datapath.
// Optional DATAPATH_SEQUENCER_STEP_EN adds a single-step PAUSE before T0.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int NUM_GPR     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        ir,
  input  logic               mem_ready,
`ifdef DATAPATH_SEQUENCER_STEP_EN
  input  logic               step,
`endif
  output logic               pc_out,
  output logic               zlow_out,
  output logic               zhigh_out,
  output logic               mdr_out,
  output logic               hi_out,
  output logic               lo_out,
  output logic               c_out,
  output logic [NUM_GPR-1:0] reg_out,
  output logic               mar_in,
  output logic               mdr_in,
  output logic               ir_in,
  output logic               y_in,
  output logic               z_in,
  output logic               pc_in,
  output logic               hi_in,
  output logic               lo_in,
  output logic [NUM_GPR-1:0] reg_in,
  output logic               inc_pc,
  output logic [3:0]         alu_ctrl,
  output logic               read,
  output logic               mem_write,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op = ir[OP_LSB +: 5];
  assign ra = ir[RA_LSB +: 4];
  assign rb = ir[RB_LSB +: 4];
  assign rc = ir[RC_LSB +: 4];
  assign unused_ir = ^ir[RC_LSB-1:0];

  logic is_rtype, is_imm, is_md, is_ld, is_st;
  logic is_mfhi, is_mflo, legal;

  assign is_rtype = op inside {OP_ADD, OP_SUB, OP_AND,
                               OP_OR, OP_SHR, OP_SHL};
  assign is_imm  = (op == OP_ADDI);
  assign is_md   = (op == OP_MUL) | (op == OP_DIV);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_mfhi = (op == OP_MFHI);
  assign is_mflo = (op == OP_MFLO);
  assign legal   = is_rtype | is_imm | is_md | is_ld | is_st
                 | is_mfhi | is_mflo
                 | (op == OP_NOP) | (op == OP_HALT);

  state_e     state_q, state_d, first_st;
  logic [7:0] cnt_q, cnt_d;
  logic       wait_st, tmo;

`ifdef DATAPATH_SEQUENCER_STEP_EN
  logic step_q, step_rise;

  // registered copy of step for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_rise = step & ~step_q;
  assign first_st  = S_PAUSE;
`else
  assign first_st  = S_T0;
`endif

  assign wait_st = (state_q == S_T1)
                 | ((state_q == S_T6) & is_ld)
                 | ((state_q == S_T7) & is_st);
  assign tmo   = wait_st & ~mem_ready & (cnt_q == TMO_LAST);
  assign cnt_d = (wait_st & ~mem_ready) ? cnt_q + 8'd1 : 8'd0;

  // next-state sequencing through the T-states
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = first_st;
`ifdef DATAPATH_SEQUENCER_STEP_EN
      S_PAUSE: if (step_rise) state_d = S_T0;
`endif
      S_T0: state_d = S_T1;
      S_T1: begin
        if (mem_ready) state_d = S_T2;
        else if (tmo)  state_d = S_FAULT;
      end
      S_T2: begin
        if (op == OP_HALT)     state_d = S_HALT;
        else if (op == OP_NOP) state_d = first_st;
        else if (!legal)       state_d = S_FAULT;
        else                   state_d = S_T3;
      end
      S_T3: begin
        if (is_mfhi | is_mflo) state_d = first_st;
        else                   state_d = S_T4;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_md | is_ld | is_st) state_d = S_T6;
        else                       state_d = first_st;
      end
      S_T6: begin
        if (is_md)          state_d = first_st;
        else if (is_st)     state_d = S_T7;
        else if (mem_ready) state_d = S_T7;
        else if (tmo)       state_d = S_FAULT;
      end
      S_T7: begin
        if (is_ld)          state_d = first_st;
        else if (mem_ready) state_d = first_st;
        else if (tmo)       state_d = S_FAULT;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // state and memory wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       rin_en, rout_en;
  logic [3:0] rin_sel, rout_sel;

  // Moore strobe decode; pc_in only in the first T1 cycle
  always_comb begin
    pc_out    = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    mdr_out   = 1'b0;
    hi_out    = 1'b0;
    lo_out    = 1'b0;
    c_out     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    pc_in     = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    inc_pc    = 1'b0;
    read      = 1'b0;
    mem_write = 1'b0;
    alu_ctrl  = ALU_ADD;
    rout_en   = 1'b0;
    rout_sel  = 4'd0;
    rin_en    = 1'b0;
    rin_sel   = 4'd0;
    unique case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        pc_in    = (cnt_q == 8'd0);
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_mfhi | is_mflo) begin
          hi_out  = is_mfhi;
          lo_out  = is_mflo;
          rin_en  = 1'b1;
          rin_sel = ra;
        end else begin
          y_in     = 1'b1;
          rout_en  = 1'b1;
          rout_sel = is_md ? ra : rb;
        end
      end
      S_T4: begin
        z_in = 1'b1;
        if (is_rtype | is_md) begin
          rout_en  = 1'b1;
          rout_sel = is_md ? rb : rc;
          alu_ctrl = alu_code(op);
        end else begin
          c_out = 1'b1;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_md) begin
          lo_in = 1'b1;
        end else if (is_ld | is_st) begin
          mar_in = 1'b1;
        end else begin
          rin_en  = 1'b1;
          rin_sel = ra;
        end
      end
      S_T6: begin
        if (is_md) begin
          zhigh_out = 1'b1;
          hi_in     = 1'b1;
        end else if (is_ld) begin
          read   = 1'b1;
          mdr_in = 1'b1;
        end else if (is_st) begin
          rout_en  = 1'b1;
          rout_sel = ra;
          mdr_in   = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          mdr_out = 1'b1;
          rin_en  = 1'b1;
          rin_sel = ra;
        end else if (is_st) begin
          mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy   = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
  assign halted = (state_q == S_HALT);
  assign fault  = (state_q == S_FAULT);

  gpr_select_decoder #(.NUM_GPR(NUM_GPR)) u_rout (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (reg_out)
  );

  gpr_select_decoder #(.NUM_GPR(NUM_GPR)) u_rin (
    .sel_i    (rin_sel),
    .en_i     (rin_en),
    .onehot_o (reg_in)
  );

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard bench for the datapath sequencer.
// Expected strobe cycles come from a register-transfer model of each opcode.
module tb_datapath_sequencer;

  localparam int TMO = 15;

  localparam logic [4:0] O_LD   = 5'b00000;
  localparam logic [4:0] O_ST   = 5'b00010;
  localparam logic [4:0] O_ADD  = 5'b00011;
  localparam logic [4:0] O_SUB  = 5'b00100;
  localparam logic [4:0] O_AND  = 5'b00101;
  localparam logic [4:0] O_OR   = 5'b00110;
  localparam logic [4:0] O_SHR  = 5'b00111;
  localparam logic [4:0] O_SHL  = 5'b01000;
  localparam logic [4:0] O_ADDI = 5'b01100;
  localparam logic [4:0] O_MUL  = 5'b01111;
  localparam logic [4:0] O_DIV  = 5'b10000;
  localparam logic [4:0] O_MFHI = 5'b10111;
  localparam logic [4:0] O_MFLO = 5'b11000;
  localparam logic [4:0] O_NOP  = 5'b11001;
  localparam logic [4:0] O_HALT = 5'b11010;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out;
    logic hi_out, lo_out, c_out;
    logic [15:0] reg_out;
    logic mar_in, mdr_in, ir_in, y_in;
    logic z_in, pc_in, hi_in, lo_in;
    logic [15:0] reg_in;
    logic inc_pc;
    logic [3:0] alu;
    logic rd, wr;
  } vec_t;

  logic clk = 0, reset = 0, start = 0, mem_ready = 0;
  logic [31:0] ir = 32'd0;
  logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out;
  logic mar_in, mdr_in, ir_in, y_in, z_in, pc_in, hi_in, lo_in;
  logic [15:0] reg_out, reg_in;
  logic inc_pc, read, mem_write, busy, halted, fault;
  logic [3:0] alu_ctrl;
`ifdef DATAPATH_SEQUENCER_STEP_EN
  logic step = 0;
  always @(negedge clk) step = ~step;
`endif

  always #5 clk = ~clk;

  datapath_sequencer #(.MEM_TIMEOUT(TMO), .NUM_GPR(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir),
    .mem_ready(mem_ready),
`ifdef DATAPATH_SEQUENCER_STEP_EN
    .step(step),
`endif
    .pc_out(pc_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .mdr_out(mdr_out), .hi_out(hi_out), .lo_out(lo_out),
    .c_out(c_out), .reg_out(reg_out), .mar_in(mar_in),
    .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .pc_in(pc_in), .hi_in(hi_in), .lo_in(lo_in), .reg_in(reg_in),
    .inc_pc(inc_pc), .alu_ctrl(alu_ctrl), .read(read),
    .mem_write(mem_write), .busy(busy), .halted(halted),
    .fault(fault)
  );

  vec_t dut_v, e;
  assign dut_v = {pc_out, zlow_out, zhigh_out, mdr_out, hi_out,
                  lo_out, c_out, reg_out, mar_in, mdr_in, ir_in,
                  y_in, z_in, pc_in, hi_in, lo_in, reg_in, inc_pc,
                  alu_ctrl, read, mem_write};

  vec_t        exp_q[$];
  int          dq[$];
  logic [31:0] pq[$];
  int          nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // memory: each access pops its ready delay in cycles
  int cur_d, acc_n;
  bit in_acc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 0;
      in_acc = 0;
    end else if (read || mem_write) begin
      if (!in_acc) begin
        cur_d = (dq.size() != 0) ? dq.pop_front() : 0;
        acc_n = 0;
        in_acc = 1;
      end
      mem_ready = (acc_n == cur_d);
      acc_n++;
      if (mem_ready) in_acc = 0;
    end else begin
      mem_ready = 0;
      in_acc = 0;
    end
  end

  // instruction feed: next instruction becomes visible during T0
  always @(negedge clk)
    if (reset && pc_out && pq.size() != 0) ir = pq.pop_front();

  // monitor: every cycle with any strobe consumes one expectation
  always @(negedge clk) begin
    if (reset && dut_v != '0) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL extra_cycle act=%h req=none", dut_v);
      end else begin
        e = exp_q.pop_front();
        if (dut_v !== e) begin
          nerr++;
          $display("FAIL strobes act=%h req=%h", dut_v, e);
        end
      end
      nchk++;
      if ($countones({pc_out, zlow_out, zhigh_out, mdr_out, hi_out,
                      lo_out, c_out, reg_out}) > 1 || !busy) begin
        nerr++;
        $display("FAIL bus_busy act=%h busy=%b req=1drv,busy",
                 dut_v, busy);
      end
    end
  end

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'h1 << r;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      O_SUB: return 4'd1;
      O_AND: return 4'd2;
      O_OR:  return 4'd3;
      O_SHR: return 4'd4;
      O_SHL: return 4'd5;
      O_MUL: return 4'd6;
      O_DIV: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op,
      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'($urandom)};
  endfunction

  // memory step: held d+1 cycles, or TMO cycles then fault
  task automatic access(input vec_t v, input int d,
                        input bit pcfirst, output bit ok);
    vec_t w;
    int n;
    n = (d < TMO) ? d + 1 : TMO;
    dq.push_back(d);
    for (int i = 0; i < n; i++) begin
      w = v;
      w.pc_in = pcfirst && (i == 0);
      exp_q.push_back(w);
    end
    ok = (d < TMO);
  endtask

  // reference: register transfers of one instruction
  task automatic model(input logic [31:0] ins, input int df,
                       input int dm);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    vec_t v;
    bit ok;
    op = ins[31:27]; ra = ins[26:23];
    rb = ins[22:19]; rc = ins[18:15];
    pq.push_back(ins);
    v = '0; v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1;
    exp_q.push_back(v);
    v = '0; v.zlow_out = 1; v.rd = 1; v.mdr_in = 1;
    access(v, df, 1, ok);
    if (!ok) return;
    v = '0; v.mdr_out = 1; v.ir_in = 1; exp_q.push_back(v);
    case (op)
      O_MFHI, O_MFLO: begin
        v = '0; v.hi_out = (op == O_MFHI); v.lo_out = (op == O_MFLO);
        v.reg_in = oh(ra); exp_q.push_back(v);
      end
      O_MUL, O_DIV: begin
        v = '0; v.reg_out = oh(ra); v.y_in = 1; exp_q.push_back(v);
        v = '0; v.reg_out = oh(rb); v.z_in = 1; v.alu = alu_of(op);
        exp_q.push_back(v);
        v = '0; v.zlow_out = 1; v.lo_in = 1; exp_q.push_back(v);
        v = '0; v.zhigh_out = 1; v.hi_in = 1; exp_q.push_back(v);
      end
      O_LD, O_ST: begin
        v = '0; v.reg_out = oh(rb); v.y_in = 1; exp_q.push_back(v);
        v = '0; v.c_out = 1; v.z_in = 1; exp_q.push_back(v);
        v = '0; v.zlow_out = 1; v.mar_in = 1; exp_q.push_back(v);
        if (op == O_LD) begin
          v = '0; v.rd = 1; v.mdr_in = 1;
          access(v, dm, 0, ok);
          if (!ok) return;
          v = '0; v.mdr_out = 1; v.reg_in = oh(ra);
          exp_q.push_back(v);
        end else begin
          v = '0; v.reg_out = oh(ra); v.mdr_in = 1;
          exp_q.push_back(v);
          v = '0; v.wr = 1;
          access(v, dm, 0, ok);
        end
      end
      O_ADDI: begin
        v = '0; v.reg_out = oh(rb); v.y_in = 1; exp_q.push_back(v);
        v = '0; v.c_out = 1; v.z_in = 1; exp_q.push_back(v);
        v = '0; v.zlow_out = 1; v.reg_in = oh(ra); exp_q.push_back(v);
      end
      O_ADD, O_SUB, O_AND, O_OR, O_SHR, O_SHL: begin
        v = '0; v.reg_out = oh(rb); v.y_in = 1; exp_q.push_back(v);
        v = '0; v.reg_out = oh(rc); v.z_in = 1; v.alu = alu_of(op);
        exp_q.push_back(v);
        v = '0; v.zlow_out = 1; v.reg_in = oh(ra); exp_q.push_back(v);
      end
      default: ;
    endcase
  endtask

  task automatic restart();
    reset = 0;
    start = 0;
    exp_q.delete(); dq.delete(); pq.delete();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic wait_end(input string nm, input bit want_fault);
    int i;
    i = 0;
    while (!(halted || fault) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_end"}, {halted, fault}, want_fault ? 2'b01 : 2'b10);
    chk({nm, "_drain"}, exp_q.size(), 0);
    chk({nm, "_quiet"}, {busy, dut_v}, '0);
  endtask

  logic [4:0] ops[13] = '{O_LD, O_ST, O_ADD, O_SUB, O_AND, O_OR,
                          O_SHR, O_SHL, O_ADDI, O_MUL, O_DIV,
                          O_MFHI, O_MFLO};

  initial begin
    int i;
    repeat (2) @(negedge clk);
    chk("rst_strobes", dut_v, '0);
    chk("rst_status", {busy, halted, fault}, 3'b000);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {busy, dut_v}, '0);

    model(32'h18918000, 0, 0);
    model(mk(O_LD, 4'd4, 4'd2, 4'd0), 3, 3);
    model(mk(O_MUL, 4'd5, 4'd6, 4'd0), 1, 0);
    model(mk(O_LD, 4'd7, 4'd3, 4'd0), 0, TMO - 1);
    model(mk(O_ST, 4'd8, 4'd9, 4'd0), TMO - 1, 2);
    model(mk(O_NOP, 4'd0, 4'd0, 4'd0), 0, 0);
    for (int k = 0; k < 16; k++)
      model(mk(ops[$urandom_range(0, 12)], 4'($urandom),
               4'($urandom), 4'($urandom)),
            $urandom_range(0, 3), $urandom_range(0, 4));
    model(mk(O_HALT, 4'd0, 4'd0, 4'd0), 0, 0);
    start = 1;
    wait_end("prog", 0);
    repeat (4) @(negedge clk);
    chk("halt_held", {halted, busy, |dut_v}, 3'b100);

    restart();
    model(mk(O_ST, 4'd1, 4'd2, 4'd0), 0, 255);
    start = 1;
    wait_end("timeout", 1);

    restart();
    model({5'b11111, 27'd0}, 0, 0);
    start = 1;
    i = 0;
    while (!ir_in && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("ill_t2", ir_in, 1);
    @(negedge clk);
    chk("ill_fault", {fault, busy, |dut_v}, 3'b100);
    chk("ill_drain", exp_q.size(), 0);

    restart();
    model(32'h18918000, 0, 0);
    start = 1;
    i = 0;
    while (!(z_in && reg_out != 0) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("add_t4", reg_out, 16'h0008);
    #2 reset = 0;
    #1 chk("async_rst", {busy, halted, fault, dut_v}, '0);
    restart();
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {busy, dut_v}, '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
